// File: rtl/i2c_scl_engine_if.sv
// Command, timing-config and SCL/strobe bundle for i2c_scl_engine.
// master = command issuer / data path, slave = the SCL engine.
interface i2c_scl_engine_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = 4
);
  logic [CNT_W-1:0] cfg_t_low;
  logic [CNT_W-1:0] cfg_t_high;
  logic [CNT_W-1:0] cfg_t_su;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             scl_in;
  logic             scl_oe;
  logic             drv_stb;
  logic             smp_stb;
  logic             sda_low_stb;
  logic             sda_rel_stb;
  logic [LEN_W-1:0] bit_idx;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cfg_t_low, cfg_t_high, cfg_t_su, cmd_valid, cmd_op, cmd_len, scl_in,
    input  cmd_ready, scl_oe, drv_stb, smp_stb, sda_low_stb, sda_rel_stb, bit_idx,
           busy, done, err
  );

  modport slave (
    input  cfg_t_low, cfg_t_high, cfg_t_su, cmd_valid, cmd_op, cmd_len, scl_in,
    output cmd_ready, scl_oe, drv_stb, smp_stb, sda_low_stb, sda_rel_stb, bit_idx,
           busy, done, err
  );
endinterface

// File: rtl/i2c_scl_engine.sv
// I2C SCL timing engine: START / XFER / STOP / RESTART sequencing with SDA strobes.
// Optional clock stretching and stretch timeout: define SCL_STRETCH_EN.
module i2c_scl_engine #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned STRETCH_MAX = 255
) (
  input logic             clk,
  input logic             rst_n,
  i2c_scl_engine_if.slave bus
);

  typedef enum logic [3:0] {
    StIdle, StStSu, StStHold, StPark, StLow, StHigh, StSpLow, StSpSu, StSpFree
  } state_e;

  localparam logic [1:0] OpStart   = 2'b00;
  localparam logic [1:0] OpXfer    = 2'b01;
  localparam logic [1:0] OpStop    = 2'b10;
  localparam logic [1:0] OpRestart = 2'b11;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0] r_t_low, r_t_high, r_t_su;
  logic [LEN_W-1:0] r_len, r_bit, w_bit_d;
  logic             r_rs, w_rs_d;  // current LOW/ST_SU belong to a RESTART
  logic             r_ready, r_busy, r_scl_oe, r_done, r_err;
  logic             r_drv, r_smp, r_low, r_rel;
  logic             w_done_d, w_err_d, w_drv_d, w_smp_d, w_low_d, w_rel_d;
  logic             w_acc, w_adv, w_end_low, w_end_high, w_end_su;

  assign w_acc      = bus.cmd_valid & r_ready;
  assign w_end_low  = (r_cnt == r_t_low - CNT_W'(1));
  assign w_end_high = (r_cnt == r_t_high - CNT_W'(1));
  assign w_end_su   = (r_cnt == r_t_su - CNT_W'(1));

`ifdef SCL_STRETCH_EN
  localparam int unsigned STR_W = $clog2(STRETCH_MAX + 1);
  logic [STR_W-1:0] r_str, w_str_d;
  logic             w_stretch_ph;
  assign w_adv = bus.scl_in;
  assign w_stretch_ph = (r_state == StHigh && !w_end_high) ||
                        (r_state == StSpSu && !w_end_su) ||
                        (r_state == StStSu && r_rs && !w_end_su);
`else
  logic w_unused;
  assign w_adv    = 1'b1;
  assign w_unused = bus.scl_in ^ (STRETCH_MAX == 0);
`endif

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_bit_d   = r_bit;
    w_rs_d    = r_rs;
    w_done_d  = 1'b0;
    w_err_d   = 1'b0;
    w_drv_d   = 1'b0;
    w_low_d   = 1'b0;
    w_rel_d   = 1'b0;
`ifdef SCL_STRETCH_EN
    w_str_d   = '0;
`endif
    unique case (r_state)
      StIdle, StPark: begin
        if (w_acc) begin
          w_cnt_d = '0;
          unique case (bus.cmd_op)
            OpStart: begin
              if (r_state == StIdle) begin
                w_state_d = StStSu;
                w_rs_d    = 1'b0;
              end else w_err_d = 1'b1;
            end
            OpXfer: begin
              if (r_state == StPark) begin
                w_bit_d = '0;
                if (bus.cmd_len == '0) w_done_d = 1'b1;
                else begin
                  w_state_d = StLow;
                  w_rs_d    = 1'b0;
                  w_drv_d   = 1'b1;
                end
              end else w_err_d = 1'b1;
            end
            OpStop: begin
              if (r_state == StPark) begin
                w_state_d = StSpLow;
                w_low_d   = 1'b1;
              end else w_err_d = 1'b1;
            end
            default: begin
              if (r_state == StPark) begin
                w_state_d = StLow;
                w_rs_d    = 1'b1;
                w_rel_d   = 1'b1;
              end else w_err_d = 1'b1;
            end
          endcase
          if (w_err_d) w_done_d = 1'b1;
        end
      end
      StStSu: begin
        if (w_end_su) begin
          w_state_d = StStHold;
          w_cnt_d   = '0;
          w_low_d   = 1'b1;
        end else if (!r_rs || w_adv) w_cnt_d = r_cnt + CNT_W'(1);
      end
      StStHold: begin
        if (w_end_su) begin
          w_state_d = StPark;
          w_rs_d    = 1'b0;
          w_done_d  = 1'b1;
        end else w_cnt_d = r_cnt + CNT_W'(1);
      end
      StLow: begin
        if (w_end_low) begin
          w_state_d = r_rs ? StStSu : StHigh;
          w_cnt_d   = '0;
        end else w_cnt_d = r_cnt + CNT_W'(1);
      end
      StHigh: begin
        if (w_end_high) begin
          w_cnt_d = '0;
          if (r_bit == r_len - LEN_W'(1)) begin
            w_state_d = StPark;
            w_done_d  = 1'b1;
          end else begin
            w_state_d = StLow;
            w_bit_d   = r_bit + LEN_W'(1);
            w_drv_d   = 1'b1;
          end
        end else if (w_adv) w_cnt_d = r_cnt + CNT_W'(1);
      end
      StSpLow: begin
        if (w_end_low) begin
          w_state_d = StSpSu;
          w_cnt_d   = '0;
        end else w_cnt_d = r_cnt + CNT_W'(1);
      end
      StSpSu: begin
        if (w_end_su) begin
          w_state_d = StSpFree;
          w_cnt_d   = '0;
          w_rel_d   = 1'b1;
        end else if (w_adv) w_cnt_d = r_cnt + CNT_W'(1);
      end
      StSpFree: begin
        if (w_end_su) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
          w_done_d  = 1'b1;
        end else w_cnt_d = r_cnt + CNT_W'(1);
      end
      default: w_state_d = StIdle;
    endcase
`ifdef SCL_STRETCH_EN
    // Slave held SCL low too long: abandon the bus without a STOP.
    if (w_stretch_ph && !bus.scl_in) begin
      if (r_str == STR_W'(STRETCH_MAX - 1)) begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
        w_rs_d    = 1'b0;
        w_done_d  = 1'b1;
        w_err_d   = 1'b1;
      end else w_str_d = r_str + STR_W'(1);
    end
`endif
    // Look ahead so the registered strobe lands on the last HIGH cycle.
    w_smp_d = (w_state_d == StHigh) && (w_cnt_d == r_t_high - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_t_low  <= CNT_W'(1);
      r_t_high <= CNT_W'(1);
      r_t_su   <= CNT_W'(1);
      r_len    <= '0;
      r_bit    <= '0;
      r_rs     <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_scl_oe <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_drv    <= 1'b0;
      r_smp    <= 1'b0;
      r_low    <= 1'b0;
      r_rel    <= 1'b0;
`ifdef SCL_STRETCH_EN
      r_str    <= '0;
`endif
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_bit    <= w_bit_d;
      r_rs     <= w_rs_d;
      if (w_acc) begin
        r_t_low  <= (bus.cfg_t_low == '0) ? CNT_W'(1) : bus.cfg_t_low;
        r_t_high <= (bus.cfg_t_high == '0) ? CNT_W'(1) : bus.cfg_t_high;
        r_t_su   <= (bus.cfg_t_su == '0) ? CNT_W'(1) : bus.cfg_t_su;
        r_len    <= bus.cmd_len;
      end
      r_ready  <= (w_state_d == StIdle) || (w_state_d == StPark);
      r_busy   <= !((w_state_d == StIdle) || (w_state_d == StPark));
      r_scl_oe <= (w_state_d == StPark) || (w_state_d == StLow) || (w_state_d == StSpLow);
      r_done   <= w_done_d;
      r_err    <= w_err_d;
      r_drv    <= w_drv_d;
      r_smp    <= w_smp_d;
      r_low    <= w_low_d;
      r_rel    <= w_rel_d;
`ifdef SCL_STRETCH_EN
      r_str    <= w_str_d;
`endif
    end
  end

  assign bus.cmd_ready   = r_ready;
  assign bus.busy        = r_busy;
  assign bus.scl_oe      = r_scl_oe;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.drv_stb     = r_drv;
  assign bus.smp_stb     = r_smp;
  assign bus.sda_low_stb = r_low;
  assign bus.sda_rel_stb = r_rel;
  assign bus.bit_idx     = r_bit;

endmodule
